// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
//   Holds one instruction from EX. A load/store waits for the data-SRAM response.
//   Load data is aligned and extended before a 150-bit bundle goes to WB.
//   A response that arrives while WB refuses is kept in a buffer.
// Ports:
//   clk, resetn                      clock (rising edge), async active-low reset
//   mem_allowin                      MEM can take an instruction from EX this cycle
//   ex_to_mem_valid / ex_to_mem_bus  instruction from EX (155 bits)
//   data_sram_data_ok / _rdata       single-cycle response pulse and its read data
//   wb_allowin                       WB can accept
//   mem_to_wb_valid / mem_to_wb_bus  completed instruction to WB (150 bits)
//   mem_to_id_bus                    forwarding/stall info to ID (39 bits)
// Configuration:
//   MEM_FWD_EN defined   -> mem_to_id_bus carries live forwarding data and a load-use block.
//   MEM_FWD_EN undefined -> mem_to_id_bus is tied to zero.
module mem_stage #(
  parameter int unsigned EX_BUS_W = 155,
  parameter int unsigned WB_BUS_W = 150
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                mem_allowin,
  input  logic                ex_to_mem_valid,
  input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [WB_BUS_W-1:0] mem_to_wb_bus,
  output logic [38:0]         mem_to_id_bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  mem_op;
    logic        mem_req;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
  } ex_bus_t;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_e;

  state_e      state_q, state_d;
  ex_bus_t     ex_q, ex_d, ex_in;
  logic [31:0] buf_q, buf_d;

  logic        mem_valid;
  logic        data_ok_hit;
  logic        data_got;
  logic        mem_ready_go;
  logic [31:0] raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign ex_in = ex_bus_t'(ex_to_mem_bus);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  // Latched instruction and response buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q  <= '0;
      buf_q <= '0;
    end else begin
      ex_q  <= ex_d;
      buf_q <= buf_d;
    end
  end

  // Next state and next data
  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    buf_d   = buf_q;
    if (ex_to_mem_valid && mem_allowin) ex_d = ex_in;
    case (state_q)
      S_EMPTY: begin
        if (ex_to_mem_valid) state_d = ex_in.mem_req ? S_WAIT : S_READY;
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          buf_d = data_sram_rdata;
          if (wb_allowin) begin
            if (ex_to_mem_valid) state_d = ex_in.mem_req ? S_WAIT : S_READY;
            else                 state_d = S_EMPTY;
          end else begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (wb_allowin) begin
          if (ex_to_mem_valid) state_d = ex_in.mem_req ? S_WAIT : S_READY;
          else                 state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake outputs; a response is usable in the very cycle it arrives
  always_comb begin
    mem_valid       = (state_q != S_EMPTY);
    data_ok_hit     = (state_q == S_WAIT) && data_sram_data_ok;
    data_got        = data_ok_hit || ((state_q == S_READY) && ex_q.mem_req);
    mem_ready_go    = !ex_q.mem_req || data_got;
    mem_allowin     = !mem_valid || (mem_ready_go && wb_allowin);
    mem_to_wb_valid = mem_valid && mem_ready_go;
  end

  // Load alignment and extension; off[0] is ignored for halfword ops
  always_comb begin
    raw = data_ok_hit ? data_sram_rdata : buf_q;
    case (ex_q.alu_result[1:0])
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      default: ld_byte = raw[31:24];
    endcase
    ld_half = ex_q.alu_result[1] ? raw[31:16] : raw[15:0];
    case (ex_q.mem_op)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'b0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'b0, ld_half};
      default: load_data = raw;
    endcase
    rf_wdata = ex_q.res_from_mem ? load_data : ex_q.alu_result;
  end

  assign mem_to_wb_bus = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata, ex_q.pc,
                          ex_q.csr_re, ex_q.csr_we, ex_q.csr_num,
                          ex_q.csr_wmask, ex_q.csr_wvalue};

`ifdef MEM_FWD_EN
  // Load-use: ID must stall while a load in MEM has no data yet
  assign mem_to_id_bus = {mem_valid && ex_q.rf_we, ex_q.rf_waddr, rf_wdata,
                          mem_valid && ex_q.res_from_mem && !mem_ready_go};
`else
  assign mem_to_id_bus = 39'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [154:0] ex_to_mem_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [149:0] mem_to_wb_bus;
  logic [38:0]  mem_to_id_bus;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_allowin      (mem_allowin),
    .ex_to_mem_valid  (ex_to_mem_valid),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_id_bus    (mem_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [154:0] mk_ex(input logic [31:0] pc, input logic rf_we,
      input logic [4:0] waddr, input logic [31:0] alu, input logic rfm,
      input logic [2:0] op, input logic req, input logic cre, input logic cwe,
      input logic [13:0] cnum, input logic [31:0] cmask, input logic [31:0] cval);
    return {pc, rf_we, waddr, alu, rfm, op, req, cre, cwe, cnum, cmask, cval};
  endfunction

  function automatic logic [149:0] mk_wb(input logic rf_we, input logic [4:0] waddr,
      input logic [31:0] wdata, input logic [31:0] pc, input logic cre, input logic cwe,
      input logic [13:0] cnum, input logic [31:0] cmask, input logic [31:0] cval);
    return {rf_we, waddr, wdata, pc, cre, cwe, cnum, cmask, cval};
  endfunction

  // Wait to the next falling edge, apply nothing new, let outputs settle
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ex_to_mem_valid = 1'b0; ex_to_mem_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_allowin = 1'b1;
    step(); #1;
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b exp=1", mem_allowin); end
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", mem_to_wb_valid); end
    total++; if (mem_to_wb_bus !== 150'b0) begin bad++; $display("FAIL reset_bus got=%h exp=0", mem_to_wb_bus); end
    total++; if (mem_to_id_bus !== 39'b0) begin bad++; $display("FAIL reset_idbus got=%h exp=0", mem_to_id_bus); end
    step(); resetn = 1'b1;
  endtask

  task automatic test_add();
    logic [149:0] exp;
    logic [38:0]  exp_id;
    step();
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk_ex(32'h0000_0100, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b010, 1'b0,
                          1'b1, 1'b0, 14'h0123, 32'hFFFF_0000, 32'hA5A5_5A5A);
    #1;
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL add_allowin_empty got=%b exp=1", mem_allowin); end
    step(); ex_to_mem_valid = 1'b0; #1;
    exp = mk_wb(1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100, 1'b1, 1'b0, 14'h0123,
                32'hFFFF_0000, 32'hA5A5_5A5A);
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", mem_to_wb_valid); end
    total++; if (mem_to_wb_bus !== exp) begin bad++; $display("FAIL add_bus got=%h exp=%h", mem_to_wb_bus, exp); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL add_allowin got=%b exp=1", mem_allowin); end
`ifdef MEM_FWD_EN
    exp_id = {1'b1, 5'd5, 32'h1234_5678, 1'b0};
`else
    exp_id = 39'b0;
`endif
    total++; if (mem_to_id_bus !== exp_id) begin bad++; $display("FAIL add_idbus got=%h exp=%h", mem_to_id_bus, exp_id); end
    step(); #1;
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL add_gone got=%b exp=0", mem_to_wb_valid); end
  endtask

  task automatic test_lb_sign();
    logic [149:0] exp;
    step();
    ex_to_mem_valid = 1'b1; wb_allowin = 1'b1;
    ex_to_mem_bus = mk_ex(32'h0000_0200, 1'b1, 5'd7, 32'h0000_1003, 1'b1, 3'b000, 1'b1,
                          1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); ex_to_mem_valid = 1'b0; #1;
      total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL lb_wait_allowin[%0d] got=%b exp=0", i, mem_allowin); end
      total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL lb_wait_valid[%0d] got=%b exp=0", i, mem_to_wb_valid); end
`ifdef MEM_FWD_EN
      total++; if (mem_to_id_bus[38] !== 1'b1 || mem_to_id_bus[0] !== 1'b1 || mem_to_id_bus[37:33] !== 5'd7) begin
        bad++; $display("FAIL lb_fwd[%0d] got we=%b waddr=%0d block=%b exp we=1 waddr=7 block=1",
                        i, mem_to_id_bus[38], mem_to_id_bus[37:33], mem_to_id_bus[0]);
      end
`else
      total++; if (mem_to_id_bus !== 39'b0) begin bad++; $display("FAIL lb_idbus[%0d] got=%h exp=0", i, mem_to_id_bus); end
`endif
    end
    step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF11; #1;
    exp = mk_wb(1'b1, 5'd7, 32'hFFFF_FF80, 32'h0000_0200, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL lb_valid got=%b exp=1", mem_to_wb_valid); end
    total++; if (mem_to_wb_bus !== exp) begin bad++; $display("FAIL lb_bus got=%h exp=%h", mem_to_wb_bus, exp); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL lb_allowin got=%b exp=1", mem_allowin); end
    step(); data_sram_data_ok = 1'b0; #1;
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL lb_gone got=%b exp=0", mem_to_wb_valid); end
  endtask

  task automatic test_lh_lhu();
    logic [2:0]  ops  [2] = '{3'b101, 3'b001};
    logic [31:0] exps [2] = '{32'h0000_BEEF, 32'hFFFF_BEEF};
    logic [31:0] got;
    for (int i = 0; i < 2; i++) begin
      step();
      ex_to_mem_valid = 1'b1; wb_allowin = 1'b1;
      ex_to_mem_bus = mk_ex(32'h0000_0300, 1'b1, 5'd9, 32'h0000_2002, 1'b1, ops[i], 1'b1,
                            1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
      step(); ex_to_mem_valid = 1'b0;
      step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0001; #1;
      got = mem_to_wb_bus[143:112];
      total++; if (mem_to_wb_valid !== 1'b1 || got !== exps[i]) begin
        bad++; $display("FAIL lh_op%b got valid=%b wdata=%h exp valid=1 wdata=%h", ops[i], mem_to_wb_valid, got, exps[i]);
      end
      step(); data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [149:0] exp;
    step();
    ex_to_mem_valid = 1'b1; wb_allowin = 1'b1;
    ex_to_mem_bus = mk_ex(32'h0000_0400, 1'b1, 5'd11, 32'h0000_3000, 1'b1, 3'b010, 1'b1,
                          1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    exp = mk_wb(1'b1, 5'd11, 32'hCAFE_F00D, 32'h0000_0400, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    step(); ex_to_mem_valid = 1'b0;
    wb_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; #1;
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL bp_valid0 got=%b exp=1", mem_to_wb_valid); end
    total++; if (mem_to_wb_bus !== exp) begin bad++; $display("FAIL bp_bus0 got=%h exp=%h", mem_to_wb_bus, exp); end
    total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL bp_allowin0 got=%b exp=0", mem_allowin); end
    step(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678; #1;
    total++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp) begin
      bad++; $display("FAIL bp_hold1 got valid=%b bus=%h exp valid=1 bus=%h", mem_to_wb_valid, mem_to_wb_bus, exp);
    end
    step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
    total++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp) begin
      bad++; $display("FAIL bp_stray_ok got valid=%b bus=%h exp valid=1 bus=%h", mem_to_wb_valid, mem_to_wb_bus, exp);
    end
    step(); data_sram_data_ok = 1'b0; wb_allowin = 1'b1; #1;
    total++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp || mem_allowin !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b allowin=%b bus=%h exp valid=1 allowin=1 bus=%h",
                      mem_to_wb_valid, mem_allowin, mem_to_wb_bus, exp);
    end
    step(); #1;
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL bp_gone got=%b exp=0", mem_to_wb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [149:0] exp_lw, exp_add;
    exp_lw  = mk_wb(1'b1, 5'd3, 32'hA5A5_0F0F, 32'h0000_0500, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    exp_add = mk_wb(1'b1, 5'd4, 32'h0000_0055, 32'h0000_0504, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    step();
    ex_to_mem_valid = 1'b1; wb_allowin = 1'b1;
    ex_to_mem_bus = mk_ex(32'h0000_0500, 1'b1, 5'd3, 32'h0000_4000, 1'b1, 3'b010, 1'b1,
                          1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    step();
    ex_to_mem_bus = mk_ex(32'h0000_0504, 1'b1, 5'd4, 32'h0000_0055, 1'b0, 3'b000, 1'b0,
                          1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    #1;
    total++; if (mem_allowin !== 1'b0 || mem_to_wb_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_wait got allowin=%b valid=%b exp allowin=0 valid=0", mem_allowin, mem_to_wb_valid);
    end
    step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA5A5_0F0F; #1;
    total++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp_lw || mem_allowin !== 1'b1) begin
      bad++; $display("FAIL b2b_lw got valid=%b allowin=%b bus=%h exp valid=1 allowin=1 bus=%h",
                      mem_to_wb_valid, mem_allowin, mem_to_wb_bus, exp_lw);
    end
    step(); data_sram_data_ok = 1'b0; ex_to_mem_valid = 1'b0; #1;
    total++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp_add) begin
      bad++; $display("FAIL b2b_add got valid=%b bus=%h exp valid=1 bus=%h", mem_to_wb_valid, mem_to_wb_bus, exp_add);
    end
    step(); #1;
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_nodup got=%b exp=0", mem_to_wb_valid); end
  endtask

  task automatic test_reset_mid_wait();
    step();
    ex_to_mem_valid = 1'b1; wb_allowin = 1'b1;
    ex_to_mem_bus = mk_ex(32'h0000_0600, 1'b1, 5'd12, 32'h0000_5004, 1'b1, 3'b010, 1'b1,
                          1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    step(); ex_to_mem_valid = 1'b0; #1;
    total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL rst_wait_allowin got=%b exp=0", mem_allowin); end
    step(); resetn = 1'b0; #1;
    total++; if (mem_to_wb_valid !== 1'b0 || mem_to_wb_bus !== 150'b0 || mem_allowin !== 1'b1) begin
      bad++; $display("FAIL rst_async got valid=%b allowin=%b bus=%h exp valid=0 allowin=1 bus=0",
                      mem_to_wb_valid, mem_allowin, mem_to_wb_bus);
    end
    step(); resetn = 1'b1;
    step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF; #1;
    total++; if (mem_to_wb_valid !== 1'b0 || mem_to_wb_bus !== 150'b0 || mem_allowin !== 1'b1) begin
      bad++; $display("FAIL rst_stray_ok got valid=%b allowin=%b bus=%h exp valid=0 allowin=1 bus=0",
                      mem_to_wb_valid, mem_allowin, mem_to_wb_bus);
    end
    total++; if (mem_to_id_bus !== 39'b0) begin bad++; $display("FAIL rst_stray_idbus got=%h exp=0", mem_to_id_bus); end
    step(); data_sram_data_ok = 1'b0; #1;
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_after got=%b exp=0", mem_to_wb_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb_sign();
    test_lh_lhu();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
